audio_seq: RTL and testbench

Parametrised multi-mode tone sequencer for the tug-of-war game speaker path. Plays a short note sequence (point beep, win melody, or loss siren) as a square wave on the board's mono audio amplifier, on request from the game controller. Generalises the fixed single-tone alarm generator with configurable pitch and durations, selectable modes, and a start/busy handshake. Sits between game control logic and the top-level audio pins.

---
 rtl/audio_seq_if.sv | 12 +
 rtl/audio_seq.sv | 173 +++++++++++++++++
 tb/tb_audio_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_seq_if.sv
// Handshake and audio-pin bundle between the game controller and the tone sequencer.
interface audio_seq_if;
  logic       start;
  logic [1:0] mode;
  logic       busy;
  logic       speaker;
  logic       gain;
  logic       en;

  modport master (output start, mode, input busy, speaker, gain, en);
  modport slave  (input start, mode, output busy, speaker, gain, en);
endinterface

// File: rtl/audio_seq.sv
// Multi-mode square-wave tone sequencer (beep / win / siren) for the speaker path.
// Optional AUDIO_REPEAT_EN: win and siren loop through a gap back to note 0 instead of stopping.
//   state | meaning
//   IDLE  | silent, amplifier disabled, waiting for start
//   PLAY  | tone running, speaker toggles every half-period
//   GAP   | silence between notes, amplifier still enabled
module audio_seq #(
  parameter int DIV_W    = 16,
  parameter int BASE_DIV = 56818,
  parameter int DUR_W    = 24,
  parameter int NOTE_LEN = 12500000,
  parameter int GAP_LEN  = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  audio_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  localparam logic [31:0] HP_FULL_32 = 32'(BASE_DIV);
  localparam logic [31:0] HP_45_32   = 32'(BASE_DIV) * 32'd4 / 32'd5;
  localparam logic [31:0] HP_23_32   = 32'(BASE_DIV) * 32'd2 / 32'd3;
  localparam logic [31:0] HP_HALF_32 = 32'(BASE_DIV) / 32'd2;

  localparam logic [DIV_W-1:0] HP_FULL = HP_FULL_32[DIV_W-1:0];
  localparam logic [DIV_W-1:0] HP_45   = HP_45_32[DIV_W-1:0];
  localparam logic [DIV_W-1:0] HP_23   = HP_23_32[DIV_W-1:0];
  localparam logic [DIV_W-1:0] HP_HALF = HP_HALF_32[DIV_W-1:0];

  localparam logic [DUR_W-1:0] NOTE_LD = DUR_W'(NOTE_LEN - 1);
  localparam logic [DUR_W-1:0] GAP_LD  = DUR_W'(GAP_LEN - 1);

  function automatic logic [DIV_W-1:0] half_period(input logic [1:0] m, input logic [1:0] idx);
    logic [DIV_W-1:0] hp;
    hp = HP_HALF;
    case (m)
      2'd2: begin
        case (idx)
          2'd0:    hp = HP_FULL;
          2'd1:    hp = HP_45;
          2'd2:    hp = HP_23;
          default: hp = HP_HALF;
        endcase
      end
      2'd3:    hp = idx[0] ? HP_FULL : HP_HALF;
      default: hp = HP_HALF;
    endcase
    return hp;
  endfunction

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [1:0]       r_note_idx;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DUR_W-1:0] r_dur_cnt;
  logic             r_speaker;
  logic             r_gain;
  logic             r_en;
  logic             r_busy;

  logic             w_last;
  logic             w_repeat;
  logic [1:0]       w_next_idx;
  logic [DIV_W-1:0] w_hp_start;
  logic [DIV_W-1:0] w_hp_cur;
  logic [DIV_W-1:0] w_hp_next;

  // Beep is a single note; win and siren both have four.
  assign w_last     = (r_mode == 2'd1) ? (r_note_idx == 2'd0) : (r_note_idx == 2'd3);
  assign w_next_idx = w_last ? 2'd0 : r_note_idx + 2'd1;
  assign w_hp_start = half_period(bus.mode, 2'd0);
  assign w_hp_cur   = half_period(r_mode, r_note_idx);
  assign w_hp_next  = half_period(r_mode, w_next_idx);

`ifdef AUDIO_REPEAT_EN
  assign w_repeat = (r_mode != 2'd1);
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_note_idx <= 2'd0;
      r_div_cnt  <= '0;
      r_dur_cnt  <= '0;
      r_speaker  <= 1'b0;
      r_gain     <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
    end else if (bus.start && (bus.mode != 2'd0)) begin
      r_state    <= S_PLAY;
      r_mode     <= bus.mode;
      r_note_idx <= 2'd0;
      r_div_cnt  <= w_hp_start - DIV_W'(1);
      r_dur_cnt  <= NOTE_LD;
      r_speaker  <= 1'b0;
      r_gain     <= 1'b1;
      r_en       <= 1'b1;
      r_busy     <= 1'b1;
    end else if (bus.start) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_note_idx <= 2'd0;
      r_div_cnt  <= '0;
      r_dur_cnt  <= '0;
      r_speaker  <= 1'b0;
      r_gain     <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_PLAY: begin
          // Note end wins over a coincident half-period toggle.
          if (r_dur_cnt == '0) begin
            if (!w_last || w_repeat) begin
              r_state   <= S_GAP;
              r_dur_cnt <= GAP_LD;
              r_div_cnt <= '0;
              r_speaker <= 1'b0;
              r_gain    <= 1'b0;
            end else begin
              r_state    <= S_IDLE;
              r_mode     <= 2'd0;
              r_note_idx <= 2'd0;
              r_div_cnt  <= '0;
              r_speaker  <= 1'b0;
              r_gain     <= 1'b0;
              r_en       <= 1'b0;
              r_busy     <= 1'b0;
            end
          end else begin
            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
            if (r_div_cnt == '0) begin
              r_speaker <= ~r_speaker;
              r_div_cnt <= w_hp_cur - DIV_W'(1);
            end else begin
              r_div_cnt <= r_div_cnt - DIV_W'(1);
            end
          end
        end
        S_GAP: begin
          if (r_dur_cnt == '0) begin
            r_state    <= S_PLAY;
            r_note_idx <= w_next_idx;
            r_div_cnt  <= w_hp_next - DIV_W'(1);
            r_dur_cnt  <= NOTE_LD;
            r_speaker  <= 1'b0;
            r_gain     <= 1'b1;
          end else begin
            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_speaker <= 1'b0;
          r_gain    <= 1'b0;
          r_en      <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.speaker = r_speaker;
  assign bus.gain    = r_gain;
  assign bus.en      = r_en;

endmodule

// File: tb/tb_audio_seq.sv
// Directed bench for audio_seq: per-sequence measurements checked against a queue of expectations.
module tb_audio_seq;
  localparam int DIV_W    = 8;
  localparam int BASE_DIV = 10;
  localparam int DUR_W    = 8;
  localparam int NOTE_LEN = 100;
  localparam int GAP_LEN  = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;

  audio_seq_if bus ();

  audio_seq #(
    .DIV_W(DIV_W), .BASE_DIV(BASE_DIV), .DUR_W(DUR_W),
    .NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int n_notes(input int m);
    return (m == 1) ? 1 : 4;
  endfunction

  function automatic int hp(input int m, input int i);
    if (m == 2) begin
      case (i)
        0:       return BASE_DIV;
        1:       return BASE_DIV * 4 / 5;
        2:       return BASE_DIV * 2 / 3;
        default: return BASE_DIV / 2;
      endcase
    end
    if (m == 3) return (i % 2 == 1) ? BASE_DIV : BASE_DIV / 2;
    return BASE_DIV / 2;
  endfunction

  // Speaker edges per note: one every h cycles after the note starts, plus a drop to 0 if it ends high.
  function automatic int exp_toggles(input int m);
    int t, sum;
    sum = 0;
    for (int i = 0; i < n_notes(m); i++) begin
      t = (NOTE_LEN - 1) / hp(m, i);
      sum += (t % 2 == 1) ? t + 1 : t;
    end
    return sum;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty: observed=%0d expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic expect_seq(input int m);
    int n;
    n = n_notes(m);
    push($sformatf("len_m%0d", m), n * NOTE_LEN + (n - 1) * GAP_LEN);
    push($sformatf("toggles_m%0d", m), exp_toggles(m));
    push($sformatf("first_toggle_m%0d", m), hp(m, 0));
    push($sformatf("gap_cycles_m%0d", m), (n - 1) * GAP_LEN);
    push($sformatf("errs_m%0d", m), 0);
  endtask

  // Called at the negedge of the cycle in which start is high; returns at the following negedge.
  task automatic kick(input logic [1:0] m);
    bus.start = 1'b1;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 2'd0;
  endtask

  // Entered at the first PLAY sample; walks until busy falls or max_cyc samples pass.
  task automatic measure(input int max_cyc, output int len, output int tog,
                         output int first, output int gapc, output int errs);
    logic prev;
    prev  = 1'b0;
    len   = 0;
    tog   = 0;
    first = -1;
    gapc  = 0;
    errs  = 0;
    while (bus.busy === 1'b1 && len < max_cyc) begin
      if (bus.speaker !== prev) begin
        tog++;
        if (first < 0) first = len;
      end
      prev = bus.speaker;
      if (bus.en !== 1'b1) errs++;
      if (bus.gain === 1'b0) begin
        gapc++;
        if (bus.speaker !== 1'b0) errs++;
      end
      len++;
      @(negedge clk);
    end
    if (bus.busy !== 1'b1) begin
      if (bus.speaker !== prev) tog++;
      if (bus.en !== 1'b0 || bus.gain !== 1'b0 || bus.speaker !== 1'b0) errs++;
    end
  endtask

  task automatic measure_and_score(input int max_cyc);
    int len, tog, first, gapc, errs;
    measure(max_cyc, len, tog, first, gapc, errs);
    pop_cmp(len);
    pop_cmp(tog);
    pop_cmp(first);
    pop_cmp(gapc);
    pop_cmp(errs);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_en"}, int'(bus.en), 0);
    chk({tag, "_gain"}, int'(bus.gain), 0);
    chk({tag, "_speaker"}, int'(bus.speaker), 0);
  endtask

  initial begin
    int spk_changes;
    logic prev_spk;
    bus.start = 1'b0;
    bus.mode  = 2'd0;

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single beep.
    expect_seq(1);
    kick(2'd1);
    chk("beep_start_gain", int'(bus.gain), 1);
    measure_and_score(200);
    repeat (5) @(negedge clk);

    // Win melody.
    expect_seq(2);
    kick(2'd2);
    measure_and_score(600);
    repeat (5) @(negedge clk);

    // Siren: once by default, looping with repeat enabled.
`ifdef AUDIO_REPEAT_EN
    kick(2'd3);
    repeat (470) @(negedge clk);
    chk("siren_loop_gap_busy", int'(bus.busy), 1);
    chk("siren_loop_gap_gain", int'(bus.gain), 0);
    repeat (14) @(negedge clk);
    chk("siren_restart_spk_lo", int'(bus.speaker), 0);
    chk("siren_restart_gain", int'(bus.gain), 1);
    @(negedge clk);
    chk("siren_restart_spk_hi", int'(bus.speaker), 1);
    repeat (515) @(negedge clk);
    chk("siren_busy_at_1000", int'(bus.busy), 1);
    kick(2'd0);
    chk_quiet("siren_loop_stop");
`else
    expect_seq(3);
    kick(2'd3);
    measure_and_score(600);
`endif
    repeat (5) @(negedge clk);

    // Pre-emption at PLAY cycle 30 of the second win note.
    kick(2'd2);
    repeat (150) @(negedge clk);
    chk("preempt_pre_busy", int'(bus.busy), 1);
    chk("preempt_pre_gain", int'(bus.gain), 1);
    expect_seq(1);
    kick(2'd1);
    chk("preempt_spk0", int'(bus.speaker), 0);
    measure_and_score(200);
    repeat (5) @(negedge clk);

    // Abort siren with mode 0.
    kick(2'd3);
    repeat (50) @(negedge clk);
    kick(2'd0);
    chk_quiet("abort");
    repeat (10) @(negedge clk);
    chk("abort_later_busy", int'(bus.busy), 0);

    // Asynchronous reset mid-note.
    kick(2'd2);
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_quiet("async_reset");
    @(negedge clk);
    rst = 1'b1;
    prev_spk = bus.speaker;
    spk_changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.speaker !== prev_spk || bus.busy !== 1'b0) spk_changes++;
      prev_spk = bus.speaker;
    end
    chk("post_reset_activity", spk_changes, 0);

    // Beep requested on the exact cycle the win's last note ends.
    kick(2'd2);
    repeat (459) @(negedge clk);
    chk("collide_pre_busy", int'(bus.busy), 1);
    expect_seq(1);
    kick(2'd1);
    chk("collide_busy", int'(bus.busy), 1);
    chk("collide_gain", int'(bus.gain), 1);
    measure_and_score(200);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
